// File: rtl/mult_hs_responder.sv
// 8x8 unsigned multiply responder: valid/ready in, 3-stage pipe, valid/ready out.
// Optional error statistics build with MULT_ERR_STATS_EN (adds out_err, err_sum).
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand channel, inA/inB unsigned operands
//   out_valid/out_ready result channel, Y product
//   busy                any stage holds an item
//   count               completed output transfers (wraps)
//   out_err, err_sum    |Y - exact| with Y, saturating sum (MULT_ERR_STATS_EN)
module mult_hs_responder #(
  parameter int WIDTH      = 8,
  parameter int TRUNC_COLS = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   inA,
  input  logic [WIDTH-1:0]   inB,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Y,
  output logic               busy,
  output logic [15:0]        count
`ifdef MULT_ERR_STATS_EN
  ,
  output logic [2*WIDTH-1:0] out_err,
  output logic [31:0]        err_sum
`endif
);

  localparam int W2 = 2 * WIDTH;
  // Columns i+j < TRUNC_COLS are dropped.
  localparam logic [W2-1:0] MASK =
    ~((W2'(1) << TRUNC_COLS) - W2'(1));
  localparam int CSH = (TRUNC_COLS > 0) ? TRUNC_COLS - 1 : 0;
  localparam logic [W2-1:0] COMP =
    (TRUNC_COLS > 0) ? (W2'(1) << CSH) : '0;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             zero;
`ifdef MULT_ERR_STATS_EN
    logic [W2-1:0]    ex;
`endif
  } s1_t;

  typedef struct packed {
    logic [W2-1:0] sum;
    logic [W2-1:0] car;
    logic          zero;
`ifdef MULT_ERR_STATS_EN
    logic [W2-1:0] ex;
`endif
  } s2_t;

  logic s1_valid;
  logic s2_valid;
  s1_t  s1_q;
  s1_t  s1_d;
  s2_t  s2_q;
  s2_t  s2_d;

  logic free1;
  logic free2;
  logic free3;

  logic [W2-1:0] y_d;

  // A stage may load when it is empty or its content moves on.
  assign free3    = !out_valid || out_ready;
  assign free2    = !s2_valid || free3;
  assign free1    = !s1_valid || free2;
  assign in_ready = rst_n && free1;
  assign busy     = s1_valid || s2_valid || out_valid;

  always_comb begin
    s1_d      = '0;
    s1_d.a    = inA;
    s1_d.b    = inB;
    s1_d.zero = (inA == '0) || (inB == '0);
`ifdef MULT_ERR_STATS_EN
    s1_d.ex   = W2'(inA) * W2'(inB);
`endif
  end

  // Masked partial products folded by a chain of 3:2 compressors.
  logic [W2-1:0] pp [WIDTH];
  logic [W2-1:0] cs_s;
  logic [W2-1:0] cs_c;
  logic [W2-1:0] cs_t;

  always_comb begin
    for (int j = 0; j < WIDTH; j++) begin
      pp[j] = (W2'(s1_q.a & {WIDTH{s1_q.b[j]}}) << j) & MASK;
    end
    cs_s = pp[0];
    cs_c = pp[1];
    cs_t = '0;
    for (int j = 2; j < WIDTH; j++) begin
      cs_t = cs_s ^ cs_c ^ pp[j];
      cs_c = ((cs_s & cs_c) | (cs_s & pp[j]) |
              (cs_c & pp[j])) << 1;
      cs_s = cs_t;
    end
    s2_d      = '0;
    s2_d.sum  = cs_s;
    s2_d.car  = cs_c;
    s2_d.zero = s1_q.zero;
`ifdef MULT_ERR_STATS_EN
    s2_d.ex   = s1_q.ex;
`endif
  end

  // A zero operand bypasses the rounding constant.
  always_comb begin
    y_d = '0;
    if (!s2_q.zero) begin
      y_d = s2_q.sum + s2_q.car + COMP;
    end
  end

`ifdef MULT_ERR_STATS_EN
  logic [W2-1:0] err_d;
  logic [32:0]   es_add;

  always_comb begin
    err_d = '0;
    if (y_d >= s2_q.ex) begin
      err_d = y_d - s2_q.ex;
    end else begin
      err_d = s2_q.ex - y_d;
    end
    es_add = {1'b0, err_sum} + 33'(out_err);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      Y         <= '0;
      count     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
`ifdef MULT_ERR_STATS_EN
      out_err   <= '0;
      err_sum   <= '0;
`endif
    end else begin
      if (free1) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (free2) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_q <= s2_d;
      end
      if (free3) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          Y <= y_d;
`ifdef MULT_ERR_STATS_EN
          out_err <= err_d;
`endif
        end
      end
      if (out_valid && out_ready) begin
        count <= count + 16'd1;
`ifdef MULT_ERR_STATS_EN
        if (es_add[32]) err_sum <= '1;
        else            err_sum <= es_add[31:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_mult_hs_responder.sv
// Bench for mult_hs_responder: exact (u0) and truncated T=4 (u4) instances.
// Scoreboard queues filled on input transfers, drained on output transfers.
module tb_mult_hs_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv0, ir0, ov0, or0, bz0;
  logic [7:0]  a0, b0;
  logic [15:0] y0, c0;

  logic        iv4, ir4, ov4, or4, bz4;
  logic [7:0]  a4, b4;
  logic [15:0] y4, c4;

`ifdef MULT_ERR_STATS_EN
  logic [15:0] e0, e4;
  logic [31:0] es0, es4;
  int unsigned qe4[$];
  int unsigned esum4;
`endif

  mult_hs_responder #(.WIDTH(8), .TRUNC_COLS(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv0), .in_ready(ir0),
    .inA(a0), .inB(b0),
    .out_valid(ov0), .out_ready(or0),
    .Y(y0), .busy(bz0), .count(c0)
`ifdef MULT_ERR_STATS_EN
    , .out_err(e0), .err_sum(es0)
`endif
  );

  mult_hs_responder #(.WIDTH(8), .TRUNC_COLS(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4),
    .inA(a4), .inB(b4),
    .out_valid(ov4), .out_ready(or4),
    .Y(y4), .busy(bz4), .count(c4)
`ifdef MULT_ERR_STATS_EN
    , .out_err(e4), .err_sum(es4)
`endif
  );

  int total = 0;
  int bad   = 0;

  int unsigned q0[$];
  int unsigned q4[$];
  int unsigned cnt0, cnt4;
  bit          hv0, hv4;
  logic [15:0] hy0, hy4;

  function automatic int unsigned model(
    input logic [7:0] a, input logic [7:0] b, input int t);
    int unsigned s;
    s = 0;
    if (a == 0 || b == 0) return 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (a[i] && b[j] && (i + j) >= t) s += 1 << (i + j);
    if (t > 0) s += 1 << (t - 1);
    return s;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, then step past the posedge.
  task automatic tick(output bit acc0, output bit acc4);
    int unsigned ex;
    @(negedge clk);
    acc0 = iv0 && ir0;
    acc4 = iv4 && ir4;
    if (!rst_n) begin
      chk("rst_in_ready0", 32'(ir0), 0);
      chk("rst_in_ready4", 32'(ir4), 0);
    end
    if (acc0) q0.push_back(model(a0, b0, 0));
    if (acc4) begin
      q4.push_back(model(a4, b4, 4));
`ifdef MULT_ERR_STATS_EN
      ex = a4 * b4;
      qe4.push_back(model(a4, b4, 4) >= ex ?
                    model(a4, b4, 4) - ex : ex - model(a4, b4, 4));
`endif
    end
    if (hv0 && ov0) chk("hold_y0", 32'(y0), 32'(hy0));
    if (hv4 && ov4) chk("hold_y4", 32'(y4), 32'(hy4));
    hv0 = ov0 && !or0;
    hy0 = y0;
    hv4 = ov4 && !or4;
    hy4 = y4;
    if (rst_n) begin
      chk("count0", 32'(c0), cnt0);
      chk("count4", 32'(c4), cnt4);
      if (ov0 && or0) begin
        if (q0.size() == 0) chk("spurious0", q0.size(), 1);
        else begin
          chk("y0", 32'(y0), q0.pop_front());
`ifdef MULT_ERR_STATS_EN
          chk("out_err0", 32'(e0), 0);
          chk("err_sum0", es0, 0);
`endif
          cnt0 = (cnt0 + 1) & 16'hFFFF;
        end
      end
      if (ov4 && or4) begin
        if (q4.size() == 0) chk("spurious4", q4.size(), 1);
        else begin
          chk("y4", 32'(y4), q4.pop_front());
`ifdef MULT_ERR_STATS_EN
          ex = qe4.pop_front();
          chk("out_err4", 32'(e4), ex);
          chk("err_sum4", es4, esum4);
          esum4 += ex;
`endif
          cnt4 = (cnt4 + 1) & 16'hFFFF;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int maxc, output int n);
    bit x0, x4;
    n = 0;
    while ((q0.size() != 0 || q4.size() != 0) && n < maxc) begin
      tick(x0, x4);
      n++;
    end
    chk("drain_left", q0.size() + q4.size(), 0);
  endtask

  task automatic clear_model();
    q0.delete();
    q4.delete();
    cnt0 = 0;
    cnt4 = 0;
    hv0  = 0;
    hv4  = 0;
`ifdef MULT_ERR_STATS_EN
    qe4.delete();
    esum4 = 0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit k0, k4;
    int n, k;
    logic [7:0] pa [4];
    logic [7:0] pb [4];

    rst_n = 1'b0;
    iv0 = 0; or0 = 1; a0 = 0; b0 = 0;
    iv4 = 0; or4 = 1; a4 = 0; b4 = 0;
    clear_model();

    // reset
    tick(k0, k4);
    tick(k0, k4);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ov0", 32'(ov0), 0);
    chk("rst_busy0", 32'(bz0), 0);
    chk("rst_count0", 32'(c0), 0);
    chk("rst_y0", 32'(y0), 0);
    chk("rst_ov4", 32'(ov4), 0);
    chk("rst_in_ready0", 32'(ir0), 1);
    @(posedge clk);
    #1;

    // 1: latency and max operands
    a0 = 8'd255; b0 = 8'd255; iv0 = 1;
    tick(k0, k4);
    chk("t1_acc", 32'(k0), 1);
    iv0 = 0;
    chk("t1_busy", 32'(bz0), 1);
    drain(10, n);
    chk("t1_latency_ticks", n, 3);
    @(negedge clk);
    chk("t1_count", 32'(c0), 1);
    @(posedge clk);
    #1;

    // 2: back-to-back, one result per cycle
    pa[0] = 23; pb[0] = 67;
    pa[1] = 67; pb[1] = 23;
    pa[2] = 0;  pb[2] = 19;
    pa[3] = 19; pb[3] = 0;
    for (int i = 0; i < 4; i++) begin
      a0 = pa[i]; b0 = pb[i]; iv0 = 1;
      tick(k0, k4);
      chk("t2_acc", 32'(k0), 1);
    end
    iv0 = 0;
    for (int i = 0; i < 3; i++) tick(k0, k4);
    chk("t2_consecutive", q0.size(), 0);
    tick(k0, k4);
    chk("t2_count", 32'(c0), 5);

    // 3: backpressure holds the pipe at 3 items
    or0 = 0; iv0 = 1; k = 0;
    a0 = 8'(k * 7 + 3); b0 = 8'(k * 5 + 1);
    for (int i = 0; i < 6; i++) begin
      tick(k0, k4);
      if (k0) begin
        k++;
        a0 = 8'(k * 7 + 3); b0 = 8'(k * 5 + 1);
      end
    end
    chk("t3_accepted", k, 3);
    @(negedge clk);
    chk("t3_in_ready", 32'(ir0), 0);
    chk("t3_ov", 32'(ov0), 1);
    @(posedge clk);
    #1;
    or0 = 1;
    n = 0;
    while (k < 7 && n < 20) begin
      tick(k0, k4);
      n++;
      if (k0) begin
        k++;
        a0 = 8'(k * 7 + 3); b0 = 8'(k * 5 + 1);
      end
    end
    iv0 = 0;
    drain(20, n);
    tick(k0, k4);
    chk("t3_count", 32'(c0), 12);

    // 4, 5: truncated columns with compensation, zero bypass
    a4 = 17; b4 = 17; iv4 = 1;
    tick(k0, k4);
    chk("t4_acc", 32'(k4), 1);
    a4 = 0; b4 = 19;
    tick(k0, k4);
    chk("t5_acc", 32'(k4), 1);
    iv4 = 0;
    drain(10, n);
    @(negedge clk);
    chk("t4_y_last_zero", 32'(y4), 0);
`ifdef MULT_ERR_STATS_EN
    chk("t4_err_sum", es4, 7);
`endif
    @(posedge clk);
    #1;

    // random traffic with random backpressure on both instances
    for (int i = 0; i < 60; i++) begin
      iv0 = 1'($urandom_range(0, 1));
      iv4 = 1'($urandom_range(0, 1));
      or0 = 1'($urandom_range(0, 1));
      or4 = 1'($urandom_range(0, 1));
      a0 = 8'($urandom); b0 = 8'($urandom);
      a4 = 8'($urandom); b4 = 8'($urandom);
      if (i % 9 == 0) a4 = 8'hFF;
      if (i % 11 == 0) b4 = 8'hFF;
      tick(k0, k4);
    end
    iv0 = 0; iv4 = 0; or0 = 1; or4 = 1;
    drain(20, n);

    // 6: reset with items in flight
    a0 = 12; b0 = 13; iv0 = 1;
    tick(k0, k4);
    a0 = 14; b0 = 15;
    tick(k0, k4);
    iv0 = 0;
    rst_n = 1'b0;
    tick(k0, k4);
    rst_n = 1'b1;
    clear_model();
    @(negedge clk);
    chk("t6_ov", 32'(ov0), 0);
    chk("t6_busy", 32'(bz0), 0);
    chk("t6_count", 32'(c0), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) tick(k0, k4);
    a0 = 9; b0 = 11; iv0 = 1;
    tick(k0, k4);
    chk("t6_acc", 32'(k0), 1);
    iv0 = 0;
    drain(10, n);
    chk("t6_latency_ticks", n, 3);
    tick(k0, k4);
    chk("t6_count_after", 32'(c0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
